// File: rtl/mult_smag_iter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : mult_pkg                                                      |
// | Description : Shared FSM state type, iteration-count helper and rounding    |
// |               mode constants for the iterative sign-magnitude multiplier.   |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package mult_pkg;

  // Sequencer states shared by the multiplier and its reviewers/benches
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Rounding modes captured alongside the operands
  localparam logic c_RND_TRUNC   = 1'b0;
  localparam logic c_RND_HALF_UP = 1'b1;

  // Number of RUN cycles needed to consume all magnitude bits of the multiplier
  function automatic int calc_iter(input int n_in, input int bpc);
    return (n_in - 1 + bpc - 1) / bpc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_smag_iter_scale.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mult_smag_scale                                               |
// | Description : Combinational Q-format post-scaler for a raw magnitude        |
// |               product: optional half-up rounding, shift by F, overflow      |
// |               detection, saturate (MULT_SAT_EN) or wrap, and negative-zero  |
// |               squash.                                                       |
// | Macro       : MULT_SAT_EN - saturate the magnitude on overflow              |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module mult_smag_scale
  import mult_pkg::*;
#(
  parameter int N_IN  = 32,
  parameter int N_OUT = 32,
  parameter int F     = 0
) (
  input  logic [2*(N_IN-1)-1:0] i_acc,
  input  logic                  i_rnd,
  input  logic                  i_s1,
  input  logic                  i_s2,
  output logic [N_OUT-1:0]      o_product,
  output logic                  o_overflow
);

  localparam int c_ACC_W = 2 * (N_IN - 1);
  // One guard bit above the accumulator for the rounding carry, and never
  // narrower than the product so the overflow slice is always well formed.
  localparam int c_W     = (c_ACC_W + 1 > N_OUT) ? c_ACC_W + 1 : N_OUT;
  localparam int c_FH    = (F > 0) ? F - 1 : 0;

  logic [c_W-1:0]   w_half;
  logic [c_W-1:0]   w_sum;
  logic [c_W-1:0]   w_scaled;
  logic [N_OUT-2:0] w_mag;
  logic             w_sign;

  assign w_half     = (i_rnd == c_RND_HALF_UP && F > 0) ? (c_W'(1) << c_FH) : '0;
  assign w_sum      = c_W'(i_acc) + w_half;
  assign w_scaled   = w_sum >> F;
  assign o_overflow = |w_scaled[c_W-1:N_OUT-1];

`ifdef MULT_SAT_EN
  assign w_mag = o_overflow ? '1 : w_scaled[N_OUT-2:0];
`else
  assign w_mag = w_scaled[N_OUT-2:0];
`endif

  // A zero magnitude is always reported as positive zero
  assign w_sign    = (i_s1 ^ i_s2) && (w_mag != '0);
  assign o_product = {w_sign, w_mag};

endmodule
`default_nettype wire

// File: rtl/mult_smag_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mult_smag_iter                                                |
// | Description : Iterative sign-magnitude fixed-point multiplier consuming     |
// |               BITS_PER_CYCLE multiplier bits per clock, with ready/valid    |
// |               handshakes on both sides and per-operation rounding.          |
// | Macro       : MULT_SAT_EN - saturate the product magnitude on overflow      |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module mult_smag_iter
  import mult_pkg::*;
#(
  parameter int N_IN           = 32,
  parameter int N_OUT          = 32,
  parameter int F              = 0,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   num1,
  input  logic [N_IN-1:0]   num2,
  input  logic              rnd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_OUT-1:0]  product,
  output logic              overflow
);

  localparam int c_M     = N_IN - 1;
  localparam int c_ACC_W = 2 * c_M;
  localparam int c_ITER  = calc_iter(N_IN, BITS_PER_CYCLE);
  localparam int c_CNT_W = (c_ITER > 1) ? $clog2(c_ITER) : 1;
  // Multiplier shift register padded to a whole number of digits so the
  // bits beyond the magnitude read as zero in the final digit.
  localparam int c_B_W   = c_ITER * BITS_PER_CYCLE;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_ACC_W-1:0] r_a;
  logic [c_ACC_W-1:0] r_acc;
  logic [c_ACC_W-1:0] w_partial;
  logic [c_B_W-1:0]   r_b;
  logic [c_CNT_W-1:0] r_step;
  logic               r_s1;
  logic               r_s2;
  logic               r_rnd;
  logic [N_OUT-1:0]   r_product;
  logic [N_OUT-1:0]   w_product;
  logic               r_overflow;
  logic               w_overflow;
  logic               w_accept;
  logic               w_last;

  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_step == c_CNT_W'(c_ITER - 1));
  // r_a is pre-shifted each cycle, so the digit product needs no variable shift
  assign w_partial = r_a * c_ACC_W'(r_b[BITS_PER_CYCLE-1:0]);

  mult_smag_scale #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT),
    .F     (F)
  ) u_scale (
    .i_acc      (r_acc),
    .i_rnd      (r_rnd),
    .i_s1       (r_s1),
    .i_s2       (r_s2),
    .o_product  (w_product),
    .o_overflow (w_overflow)
  );

  // State register; en low freezes the sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else if (en) begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = FIN;
      FIN:     w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake outputs, masked while the clock enable is low
  always_comb begin
    in_ready  = en && (r_state == IDLE);
    out_valid = en && (r_state == DONE);
  end

  // Operand capture, shift-add accumulation and result registration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_step     <= '0;
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_rnd      <= 1'b0;
      r_product  <= '0;
      r_overflow <= 1'b0;
    end else if (en) begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_s1   <= num1[N_IN-1];
            r_s2   <= num2[N_IN-1];
            r_rnd  <= rnd;
            r_a    <= c_ACC_W'(num1[c_M-1:0]);
            r_b    <= c_B_W'(num2[c_M-1:0]);
            r_acc  <= '0;
            r_step <= '0;
          end
        end
        RUN: begin
          r_acc  <= r_acc + w_partial;
          r_a    <= r_a << BITS_PER_CYCLE;
          r_b    <= r_b >> BITS_PER_CYCLE;
          r_step <= r_step + c_CNT_W'(1);
        end
        FIN: begin
          r_product  <= w_product;
          r_overflow <= w_overflow;
        end
        default: begin
        end
      endcase
    end
  end

  assign product  = r_product;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_mult_smag_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mult_smag_iter                                             |
// | Description : Self-checking bench for mult_smag_iter (Q16.16, radix 2 and   |
// |               radix 16 instances) against an arithmetic reference model.    |
// | Macro       : MULT_SAT_EN - selects saturating expectations                 |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_mult_smag_iter;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, en, in_valid, rnd, out_ready, sel;
  logic [31:0] num1, num2;
  logic        iv_a, iv_b;
  logic        in_ready_a, in_ready_b, out_valid_a, out_valid_b, ovf_a, ovf_b;
  logic [31:0] product_a, product_b;
  logic        cur_in_ready, cur_out_valid, cur_ovf;
  logic [31:0] cur_product;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  assign iv_a          = in_valid & ~sel;
  assign iv_b          = in_valid & sel;
  assign cur_in_ready  = sel ? in_ready_b  : in_ready_a;
  assign cur_out_valid = sel ? out_valid_b : out_valid_a;
  assign cur_ovf       = sel ? ovf_b       : ovf_a;
  assign cur_product   = sel ? product_b   : product_a;

  mult_smag_iter #(.N_IN(32), .N_OUT(32), .F(16), .BITS_PER_CYCLE(1)) dut_a (
    .clk(clk), .rst(rst_a), .en(en), .in_valid(iv_a), .in_ready(in_ready_a),
    .num1(num1), .num2(num2), .rnd(rnd), .out_valid(out_valid_a),
    .out_ready(out_ready), .product(product_a), .overflow(ovf_a)
  );

  mult_smag_iter #(.N_IN(32), .N_OUT(32), .F(16), .BITS_PER_CYCLE(4)) dut_b (
    .clk(clk), .rst(rst_b), .en(en), .in_valid(iv_b), .in_ready(in_ready_b),
    .num1(num1), .num2(num2), .rnd(rnd), .out_valid(out_valid_b),
    .out_ready(out_ready), .product(product_b), .overflow(ovf_b)
  );

  // Reference: exact magnitude product, optional +0.5 LSB, drop 16 fraction bits
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input logic r, output logic [31:0] p, output logic o);
    logic [63:0] raw;
    logic [63:0] scaled;
    logic [30:0] mag;
    logic        s;
    raw = {33'd0, a[30:0]} * {33'd0, b[30:0]};
    if (r) raw = raw + 64'd32768;
    scaled = raw >> 16;
    o = (scaled >= 64'h0000_0000_8000_0000);
    mag = scaled[30:0];
`ifdef MULT_SAT_EN
    if (o) mag = '1;
`endif
    s = (a[31] ^ b[31]) && (mag != 31'd0);
    p = {s, mag};
  endfunction

  // Issue one operation to the selected instance and wait for its result
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic r,
                       output logic [31:0] p, output logic o, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!cur_in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    num1 = a; num2 = b; rnd = r; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!cur_out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    p = cur_product;
    o = cur_ovf;
  endtask

  task automatic test_reset();
    n_vec++;
    if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin
      n_err++; $display("FAIL reset_hs_a: got rdy=%b vld=%b expected rdy=1 vld=0", in_ready_a, out_valid_a);
    end
    n_vec++;
    if (product_a !== 32'd0 || ovf_a !== 1'b0) begin
      n_err++; $display("FAIL reset_out_a: got %h/%b expected 00000000/0", product_a, ovf_a);
    end
    n_vec++;
    if (in_ready_b !== 1'b1 || out_valid_b !== 1'b0 || product_b !== 32'd0) begin
      n_err++; $display("FAIL reset_b: got rdy=%b vld=%b p=%h expected 1/0/00000000", in_ready_b, out_valid_b, product_b);
    end
  endtask

  task automatic test_basic();
    logic [31:0] p; logic o; int lat;
    sel = 1'b0;
    do_op(32'h0001_8000, 32'h8002_0000, 1'b0, p, o, lat);
    n_vec++;
    if (p !== 32'h8003_0000 || o !== 1'b0) begin
      n_err++; $display("FAIL basic_product: got %h/%b expected 80030000/0", p, o);
    end
    n_vec++;
    if (lat != 32) begin
      n_err++; $display("FAIL basic_latency: got %0d expected 32", lat);
    end
  endtask

  task automatic test_rounding();
    logic [31:0] p; logic o; int lat;
    sel = 1'b0;
    do_op(32'h0000_0001, 32'h0000_8000, 1'b0, p, o, lat);
    n_vec++;
    if (p !== 32'h0000_0000) begin
      n_err++; $display("FAIL round_trunc: got %h expected 00000000", p);
    end
    do_op(32'h0000_0001, 32'h0000_8000, 1'b1, p, o, lat);
    n_vec++;
    if (p !== 32'h0000_0001) begin
      n_err++; $display("FAIL round_half_up: got %h expected 00000001", p);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] p; logic o; int lat; logic [31:0] exp_p;
`ifdef MULT_SAT_EN
    exp_p = 32'h7FFF_FFFF;
`else
    exp_p = 32'h7FFE_0000;
`endif
    sel = 1'b0;
    do_op(32'h7FFF_0000, 32'h0002_0000, 1'b0, p, o, lat);
    n_vec++;
    if (o !== 1'b1 || p !== exp_p) begin
      n_err++; $display("FAIL overflow: got %h/%b expected %h/1", p, o, exp_p);
    end
  endtask

  task automatic test_neg_zero();
    logic [31:0] p; logic o; int lat;
    sel = 1'b0;
    do_op(32'h8000_0000, 32'h0001_0000, 1'b0, p, o, lat);
    n_vec++;
    if (p !== 32'h0000_0000 || o !== 1'b0) begin
      n_err++; $display("FAIL neg_zero: got %h/%b expected 00000000/0", p, o);
    end
  endtask

  task automatic test_random(input logic s, input int count, input int exp_lat);
    logic [31:0] a, b, p, ep; logic o, eo, r; int lat;
    sel = s;
    for (int i = 0; i < count; i++) begin
      a = $urandom; b = $urandom;
      a[30:0] = a[30:0] >> $urandom_range(0, 20);
      b[30:0] = b[30:0] >> $urandom_range(0, 20);
      r = 1'($urandom_range(0, 1));
      model(a, b, r, ep, eo);
      do_op(a, b, r, p, o, lat);
      n_vec++;
      if (p !== ep || o !== eo || lat != exp_lat) begin
        n_err++;
        $display("FAIL random_%0d: %h x %h rnd=%b got %h/%b lat %0d expected %h/%b lat %0d",
                 s, a, b, r, p, o, lat, ep, eo, exp_lat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, p, ep; logic o, eo; int lat, guard; logic bad;
    sel = 1'b0; guard = 0;
    @(negedge clk);
    while (!in_ready_a && guard < 200) begin @(negedge clk); guard++; end
    out_ready = 1'b0;
    a = 32'h0003_4000; b = 32'h8001_2000;
    model(a, b, 1'b1, ep, eo);
    do_op(a, b, 1'b1, p, o, lat);
    n_vec++;
    if (p !== ep || o !== eo) begin
      n_err++; $display("FAIL bp_product: got %h/%b expected %h/%b", p, o, ep, eo);
    end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid_a !== 1'b1 || product_a !== ep || ovf_a !== eo || in_ready_a !== 1'b0) bad = 1'b1;
    end
    n_vec++;
    if (bad) begin
      n_err++; $display("FAIL bp_hold: got vld=%b p=%h rdy=%b expected 1/%h/0", out_valid_a, product_a, in_ready_a, ep);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin
      n_err++; $display("FAIL bp_release: got rdy=%b vld=%b expected 1/0", in_ready_a, out_valid_a);
    end
  endtask

  task automatic test_enable();
    logic [31:0] a, b, ep; logic eo; int lat, guard; logic bad;
    sel = 1'b0; guard = 0;
    a = 32'h0002_8000; b = 32'h0004_4000;
    model(a, b, 1'b0, ep, eo);
    @(negedge clk);
    while (!in_ready_a && guard < 200) begin @(negedge clk); guard++; end
    num1 = a; num2 = b; rnd = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; lat++; end
    @(negedge clk);
    en = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1; lat++;
      if (out_valid_a !== 1'b0 || in_ready_a !== 1'b0) bad = 1'b1;
    end
    n_vec++;
    if (bad) begin
      n_err++; $display("FAIL en_mask: got vld=%b rdy=%b expected 0/0", out_valid_a, in_ready_a);
    end
    @(negedge clk);
    en = 1'b1;
    while (!out_valid_a && lat < 200) begin @(posedge clk); #1; lat++; end
    n_vec++;
    if (lat != 37 || product_a !== ep || ovf_a !== eo) begin
      n_err++; $display("FAIL en_freeze: got %h/%b lat %0d expected %h/%b lat 37", product_a, ovf_a, lat, ep, eo);
    end
  endtask

  task automatic test_radix4();
    logic [31:0] p; logic o; int lat; logic bad;
    sel = 1'b1;
    do_op(32'h0003_0000, 32'h0005_0000, 1'b0, p, o, lat);
    n_vec++;
    if (p !== 32'h000F_0000 || o !== 1'b0 || lat != 9) begin
      n_err++; $display("FAIL radix4: got %h/%b lat %0d expected 000f0000/0 lat 9", p, o, lat);
    end
    // Second operation, interrupted by reset during its 5th RUN cycle
    @(negedge clk);
    while (!in_ready_b) @(negedge clk);
    num1 = 32'h0007_0000; num2 = 32'h0002_0000; rnd = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    n_vec++;
    if (out_valid_b !== 1'b0 || product_b !== 32'd0 || in_ready_b !== 1'b1) begin
      n_err++; $display("FAIL radix4_reset: got vld=%b p=%h rdy=%b expected 0/00000000/1", out_valid_b, product_b, in_ready_b);
    end
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid_b !== 1'b0) bad = 1'b1;
    end
    n_vec++;
    if (bad) begin
      n_err++; $display("FAIL radix4_discard: got vld=1 expected 0");
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    sel = 1'b0; rnd = 1'b0; num1 = '0; num2 = '0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_rounding();
    test_overflow();
    test_neg_zero();
    test_backpressure();
    test_enable();
    test_random(1'b0, 24, 32);
    test_radix4();
    test_random(1'b1, 12, 9);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_smag_iter.md
# mult_smag_iter

Iterative sign-magnitude fixed-point multiplier with ready/valid handshakes, configurable radix, and selectable per-operation rounding. It processes BITS_PER_CYCLE multiplier bits per clock and holds its result until a consumer accepts it. It sits in the flight-controller arithmetic datapath between the sensor-fusion/PID sequencers and the state registers, replacing the radix-2 start/done multiplier where throughput or back-pressure matters.

## Interface
- N_IN, 32: operand width including sign bit (≥3)
- N_OUT, 32: product width including sign bit (≥3)
- F, 0: fractional bits of Q-format, applied to operands and product (0 ≤ F < N_IN-1)
- BITS_PER_CYCLE, 1: multiplier bits consumed per RUN cycle (1, 2, 4, 8)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  clock enable; low freezes all state and forces in_ready/out_valid low
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands (en && state==IDLE)
- num1, num2  in  N_IN  sign-magnitude operands
- rnd  in  1  captured with operands: 1 = round-half-up, 0 = truncate
- out_valid  out  1  product valid (en && state==DONE)
- out_ready  in  1  consumer accepts product
- product  out  N_OUT  sign-magnitude result, stable while out_valid
- overflow  out  1  scaled magnitude exceeded N_OUT-1 bits, qualified by out_valid

## Operation
- States: IDLE, RUN, FIN, DONE (shared enum).
- IDLE: on in_valid && in_ready, capture sign bits, magnitudes, rnd; clear accumulator (2*(N_IN-1) bits) and step counter; go to RUN.
- RUN: per cycle, add (a × b[step +: BITS_PER_CYCLE]) << step to accumulator, where b bits beyond N_IN-2 read as zero; step += BITS_PER_CYCLE. After ITER = ceil((N_IN-1)/BITS_PER_CYCLE) cycles, go to FIN.
- FIN: scaled = (acc + (rnd && F>0 ? 2^(F-1) : 0)) >> F, computed at full width plus 1 bit; overflow = scaled ≥ 2^(N_OUT-1); mag = low N_OUT-1 bits of scaled; sign = s1 ^ s2, forced to 0 when mag == 0 (no negative zero). Register product and overflow; go to DONE.
- DONE: hold product and overflow; on out_ready go to IDLE. New operands are not accepted in DONE.
- in_valid while busy is ignored; the upstream holds it.
- Reset (any state, including mid-RUN): state IDLE, product 0, overflow 0, accumulator and counters 0; the in-flight operation is discarded.

## Timing
- Accept edge E0. Out_valid goes high after edge E0+ITER+1 and stays high until the out_ready edge. Default latency is 32 edges; with BITS_PER_CYCLE=4 it is 9 edges.
- The minimum issue interval is ITER+3 cycles with out_ready tied high.
- product and overflow change only on the FIN edge and on reset.
- en low: no state, counter, or output register changes, and the handshakes are masked. en has no effect on rst.

## Configuration
- MULT_SAT_EN defined: on overflow, mag saturates to all ones (2^(N_OUT-1)-1) and the sign is kept; overflow still reads 1.
- MULT_SAT_EN undefined: the magnitude wraps to its low N_OUT-1 bits; overflow reads 1.

## Structure
- Package mult_pkg holds the state_t enum (IDLE, RUN, FIN, DONE), the localparam function for ITER, and the rounding-mode constants.
- The datapath has one sub-module, mult_smag_scale. It is combinational and performs rounding, shifting, overflow detection, saturation or wrap, and negative-zero squash, parametrised like the parent, so it can be reused by other fixed-point blocks.

## Test plan
Default parameters are N_IN=N_OUT=32, F=16, BITS_PER_CYCLE=1 unless a line says otherwise.
- 0x00018000 × 0x80020000 (1.5 × -2.0) → product 0x80030000, overflow 0, out_valid 32 edges after accept.
- 0x00000001 × 0x00008000: with rnd=0 → product 0x00000000; with rnd=1 → product 0x00000001.
- 0x7FFF0000 × 0x00020000 → overflow 1. With MULT_SAT_EN the product is 0x7FFFFFFF; without it the product is 0x7FFE0000.
- 0x80000000 × 0x00010000 (-0 × 1.0) → product 0x00000000.
- Hold out_ready low for 10 cycles after out_valid → out_valid, product, and overflow stay stable and in_ready stays 0. Then raise out_ready → in_ready is 1 the next cycle.
- BITS_PER_CYCLE=4, 0x00030000 × 0x00050000 → 0x000F0000 after 9 edges. Assert rst during the 5th RUN cycle → out_valid 0, product 0, in_ready 1 after release.
